axi_lite_controller: RTL and testbench
======================================

// Module: axi_lite_controller
// PURPOSE
//  Responder end of axi_controller_if: serves single-word read/write requests from the
//  icache/dcache (amif.read/write/addr/store) as AXI4-Lite master transactions toward the
//  SoC interconnect. Returns data via amif.load/amif.ready and holds it until amif.done.
//  Sits between the cache and the AXI fabric; exactly one outstanding transaction.
// PARAMETERS
//  ADDR_W  32  AXI address width (amif.addr is word_t, zero-extended or truncated)
//  DATA_W  32  data width; must equal word_t width
// PORTS
//  clk              in   1       system clock
//  nrst             in   1       asynchronous, active-low reset
//  amif.read        in   1       cache read request (level, held until done)
//  amif.write       in   1       cache write request (level, held until done)
//  amif.addr        in   32      byte address of request
//  amif.store       in   32      write data
//  amif.done        in   1       cache accepted the response; closes transaction
//  amif.ready       out  1       response valid (load valid for reads)
//  amif.load        out  32      read data
//  m_axi_araddr/arvalid/arready  out/out/in  ADDR_W/1/1  read address channel
//  m_axi_rdata/rresp/rvalid/rready  in/in/in/out  DATA_W/2/1/1  read data channel
//  m_axi_awaddr/awvalid/awready  out/out/in  ADDR_W/1/1  write address channel
//  m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  DATA_W/4/1/1  write data channel
//  m_axi_bresp/bvalid/bready     in/in/out  2/1/1  write response channel
//  m_axi_arprot/awprot           out  3   tied 3'b000
// BEHAVIOUR
//  Reset (async, nrst=0): state=IDLE; all *valid, rready, bready, amif.ready = 0;
//   amif.load = 0; address/data regs = 0. Reset mid-transaction drops valids immediately.
//  FSM: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
//  IDLE: read -> latch addr, RD_ADDR; else write -> latch addr+store, WR_REQ.
//   Read and write both high: read wins.
//  RD_ADDR: arvalid=1, araddr stable; on arvalid&arready -> RD_DATA.
//  RD_DATA: rready=1; on rvalid -> latch rdata into load, RESP.
//  WR_REQ: awvalid, wvalid raised together, wstrb=4'hF; each drops independently
//   after its handshake (aw_done/w_done flags); both done -> WR_RESP. Same-cycle
//   handshake of both channels is legal -> WR_RESP next cycle.
//  WR_RESP: bready=1; on bvalid -> RESP.
//  RESP: amif.ready=1, load held; on amif.done -> IDLE. If read and write both
//   drop without done -> IDLE (response discarded). New request is sampled only in
//   IDLE, so a request still high in the done cycle does not restart.
//  Valids never drop before handshake; address/data never change while valid.
//  Latency with zero-wait slave: read request edge -> amif.ready 3 cycles; write 3 cycles.
//  rresp/bresp ignored unless AXI_CTRL_ERR_EN.
// CONFIGURATION
//  AXI_CTRL_ERR_EN defined: extra output amif_err (1 bit, reset 0), valid with
//   amif.ready; =1 when latched rresp/bresp != OKAY; read load forced to 32'h0 on error.
//  Undefined: no amif_err port; responses treated as OKAY, rdata passed unchanged.
// STRUCTURE
//  common_types_pkg: axi_resp_t enum (OKAY, EXOKAY, SLVERR, DECERR),
//   axi_ctrl_state_t enum, AXI_PROT_DEFAULT = 3'b000.
//  Single module; no sub-module (write-channel tracking is two flags in-line).
// TESTING
//  Read addr 0x0000_1000, slave arready/rvalid immediate, rdata 0xCAFE_F00D ->
//   ready 3 cycles after request, load=0xCAFE_F00D held until done, then IDLE.
//  Write addr 0x10, store 0x1234_5678, wready 2 cycles before awready -> wvalid drops
//   after its handshake, awvalid held; bready after both; ready once bvalid.
//  read=write=1 in IDLE, addr 0x20 -> only arvalid raised; no awvalid/wvalid.
//  arready stalled 5 cycles -> arvalid and araddr stable all 5; nrst=0 in RD_DATA ->
//   rready/ready=0 at once, state IDLE after release.
//  Hold done low 4 cycles in RESP -> ready and load stable; done with read still high ->
//   IDLE, new arvalid only the cycle after.
//  AXI_CTRL_ERR_EN: rresp=2'b10 -> amif_err=1, load=0; bresp=OKAY -> amif_err=0.

Source files
------------

// File: rtl/common_types_pkg.sv
// Shared AXI4-Lite response codes, controller state encoding and protection default.
package common_types_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    RESP
  } axi_ctrl_state_t;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi_lite_controller.sv
// Cache-side responder that turns single-word amif read/write requests into AXI4-Lite
// master transactions, one at a time. Define AXI_CTRL_ERR_EN to report SLVERR/DECERR on amif_err.
module axi_lite_controller
  import common_types_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              amif_read,
  input  logic              amif_write,
  input  logic [31:0]       amif_addr,
  input  logic [DATA_W-1:0] amif_store,
  input  logic              amif_done,
  output logic              amif_ready,
  output logic [DATA_W-1:0] amif_load,
`ifdef AXI_CTRL_ERR_EN
  output logic              amif_err,
`endif
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  output logic [2:0]        m_axi_arprot,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [2:0]        m_axi_awprot,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready
);

  axi_ctrl_state_t   r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_load;
  logic              r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready, r_ready;
  logic              r_aw_done, r_w_done;

  logic              w_ar_hs, w_aw_hs, w_w_hs, w_aw_fin, w_w_fin, w_resp_close;
  logic [DATA_W-1:0] w_rd_data;

  assign w_ar_hs  = r_arvalid & m_axi_arready;
  assign w_aw_hs  = r_awvalid & m_axi_awready;
  assign w_w_hs   = r_wvalid & m_axi_wready;
  // A channel counts as finished if it completed earlier or completes this cycle.
  assign w_aw_fin = r_aw_done | w_aw_hs;
  assign w_w_fin  = r_w_done | w_w_hs;
  // Dropping both request lines abandons the response.
  assign w_resp_close = amif_done | ~(amif_read | amif_write);

`ifdef AXI_CTRL_ERR_EN
  logic w_rd_err, w_wr_err, r_err;

  assign w_rd_err  = axi_resp_t'(m_axi_rresp) != OKAY;
  assign w_wr_err  = axi_resp_t'(m_axi_bresp) != OKAY;
  assign w_rd_data = w_rd_err ? '0 : m_axi_rdata;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_err <= 1'b0;
    end else if (r_state == RD_DATA && m_axi_rvalid) begin
      r_err <= w_rd_err;
    end else if (r_state == WR_RESP && m_axi_bvalid) begin
      r_err <= w_wr_err;
    end else if (r_state == RESP && w_resp_close) begin
      r_err <= 1'b0;
    end
  end

  assign amif_err = r_err;
`else
  logic w_unused_resp;

  assign w_unused_resp = ^{m_axi_rresp, m_axi_bresp};
  assign w_rd_data     = m_axi_rdata;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_load    <= '0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_ready   <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (amif_read) begin
            r_addr    <= ADDR_W'(amif_addr);
            r_arvalid <= 1'b1;
            r_state   <= RD_ADDR;
          end else if (amif_write) begin
            r_addr    <= ADDR_W'(amif_addr);
            r_wdata   <= amif_store;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= WR_REQ;
          end
        end
        RD_ADDR: begin
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axi_rvalid) begin
            r_rready <= 1'b0;
            r_load   <= w_rd_data;
            r_ready  <= 1'b1;
            r_state  <= RESP;
          end
        end
        WR_REQ: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_fin && w_w_fin) begin
            r_bready <= 1'b1;
            r_state  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axi_bvalid) begin
            r_bready <= 1'b0;
            r_ready  <= 1'b1;
            r_state  <= RESP;
          end
        end
        RESP: begin
          if (w_resp_close) begin
            r_ready <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign amif_ready    = r_ready;
  assign amif_load     = r_load;
  assign m_axi_araddr  = r_addr;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_arprot  = AXI_PROT_DEFAULT;
  assign m_axi_rready  = r_rready;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_awprot  = AXI_PROT_DEFAULT;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;

endmodule

// File: tb/tb_axi_lite_controller.sv
// Directed plus randomized bench: a latency-configurable AXI-Lite slave with word memory,
// and a transaction-level memory model predicting load data and response latency.
module tb_axi_lite_controller;

  logic        clk = 1'b0;
  logic        nrst;
  logic        amif_read, amif_write, amif_done, amif_ready;
  logic [31:0] amif_addr, amif_store, amif_load;
`ifdef AXI_CTRL_ERR_EN
  logic        amif_err;
`endif
  logic [31:0] m_axi_araddr, m_axi_rdata, m_axi_awaddr, m_axi_wdata;
  logic        m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready;
  logic [1:0]  m_axi_rresp, m_axi_bresp;
  logic [2:0]  m_axi_arprot, m_axi_awprot;
  logic [3:0]  m_axi_wstrb;

  always #5 clk = ~clk;

  axi_lite_controller #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .nrst(nrst),
    .amif_read(amif_read), .amif_write(amif_write), .amif_addr(amif_addr),
    .amif_store(amif_store), .amif_done(amif_done), .amif_ready(amif_ready),
    .amif_load(amif_load),
`ifdef AXI_CTRL_ERR_EN
    .amif_err(amif_err),
`endif
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_arprot(m_axi_arprot),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awprot(m_axi_awprot),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // slave configuration and state
  int          ar_lat, r_lat, aw_lat, w_lat, b_lat;
  logic [1:0]  cfg_rresp, cfg_bresp;
  int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt, ar_stalls;
  bit          rd_pend, aw_got, w_got;
  logic [31:0] s_rd_addr, s_wr_addr, s_wr_data;
  logic [3:0]  s_wr_strb;
  logic [31:0] smem [logic [31:0]];
  // reference model
  logic [31:0] emem [logic [31:0]];
  logic [31:0] exp_load;
  // protocol monitor
  bit          p_arv, p_awv, p_wv, forbid_wr, saw_wr, w_first;
  logic [31:0] p_araddr, p_awaddr, p_wdata;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return emem.exists(a) ? emem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    return smem.exists(a) ? smem[a] : init_word(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic slave_clear();
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    rd_pend = 0; aw_got = 0; w_got = 0;
    p_arv = 0; p_awv = 0; p_wv = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = '0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = '0;
  endtask

  // Runs at each falling edge: checks what the DUT held since the last rising edge,
  // then drives the slave side for the next rising edge.
  task automatic slave();
    bit ar_hs, r_go, aw_hs, w_hs, b_go;
    if (p_arv) chk("ar_stable", {m_axi_arvalid, m_axi_araddr}, {1'b1, p_araddr});
    if (p_awv) chk("aw_stable", {m_axi_awvalid, m_axi_awaddr}, {1'b1, p_awaddr});
    if (p_wv)  chk("w_stable",  {m_axi_wvalid, m_axi_wdata},   {1'b1, p_wdata});
    if (m_axi_arvalid || m_axi_awvalid || m_axi_wvalid)
      chk("one_outstanding", m_axi_arvalid && (m_axi_awvalid || m_axi_wvalid), 0);
    if (forbid_wr && (m_axi_awvalid || m_axi_wvalid)) saw_wr = 1;
    if (!m_axi_wvalid && m_axi_awvalid && w_got) w_first = 1;

    b_go  = aw_got && w_got && b_cnt >= b_lat;
    r_go  = rd_pend && r_cnt >= r_lat;
    ar_hs = m_axi_arvalid && ar_cnt >= ar_lat;
    aw_hs = m_axi_awvalid && aw_cnt >= aw_lat;
    w_hs  = m_axi_wvalid && w_cnt >= w_lat;

    m_axi_arready = ar_hs;
    m_axi_rvalid  = r_go;
    m_axi_rdata   = r_go ? slave_rd(s_rd_addr) : $urandom;
    m_axi_rresp   = r_go ? cfg_rresp : 2'($urandom_range(0, 3));
    m_axi_awready = aw_hs;
    m_axi_wready  = w_hs;
    m_axi_bvalid  = b_go;
    m_axi_bresp   = cfg_bresp;

    if (m_axi_arvalid && !ar_hs) begin ar_cnt++; ar_stalls++; end
    if (m_axi_awvalid && !aw_hs) aw_cnt++;
    if (m_axi_wvalid && !w_hs) w_cnt++;
    if (rd_pend && !r_go) r_cnt++;
    if (aw_got && w_got && !b_go) b_cnt++;
    if (r_go && m_axi_rready) rd_pend = 0;
    if (b_go && m_axi_bready) begin
      smem[s_wr_addr] = s_wr_data;
      aw_got = 0; w_got = 0; b_cnt = 0;
    end
    if (ar_hs) begin rd_pend = 1; r_cnt = 0; ar_cnt = 0; s_rd_addr = m_axi_araddr; end
    if (aw_hs) begin aw_got = 1; aw_cnt = 0; s_wr_addr = m_axi_awaddr; end
    if (w_hs)  begin w_got = 1; w_cnt = 0; s_wr_data = m_axi_wdata; s_wr_strb = m_axi_wstrb; end

    p_arv = m_axi_arvalid && !ar_hs; p_araddr = m_axi_araddr;
    p_awv = m_axi_awvalid && !aw_hs; p_awaddr = m_axi_awaddr;
    p_wv  = m_axi_wvalid && !w_hs;   p_wdata  = m_axi_wdata;
  endtask

  task automatic tick();
    @(negedge clk);
    slave();
  endtask

  task automatic set_lat(input int a, input int r, input int aw, input int w, input int b);
    ar_lat = a; r_lat = r; aw_lat = aw; w_lat = w; b_lat = b;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk(tag, {m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, amif_ready}, 0);
  endtask

  // Waits for amif.ready, checks the response, then holds done low for 'hold' cycles.
  task automatic txn_wait(input int exp_lat, input bit is_rd, input logic [31:0] addr,
                          input logic [31:0] data, input int hold);
    int n = 0;
    while (!amif_ready && n < 100) begin tick(); n++; end
    chk("resp_timeout", amif_ready, 1);
    if (exp_lat >= 0) chk("latency", n, exp_lat);
    if (is_rd) begin
`ifdef AXI_CTRL_ERR_EN
      exp_load = (cfg_rresp != 2'b00) ? 32'h0 : model_rd(addr);
`else
      exp_load = model_rd(addr);
`endif
      chk("araddr", s_rd_addr, addr);
    end else begin
      chk("awaddr", s_wr_addr, addr);
      chk("wdata_strb", {s_wr_strb, s_wr_data}, {4'hF, data});
      emem[addr] = data;
    end
    chk("load", amif_load, exp_load);
`ifdef AXI_CTRL_ERR_EN
    chk("err", amif_err, is_rd ? (cfg_rresp != 2'b00) : (cfg_bresp != 2'b00));
`endif
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("resp_hold", {amif_ready, amif_load}, {1'b1, exp_load});
    end
  endtask

  task automatic txn_close(input bit keep);
    amif_done = 1;
    tick();
    chk("ready_drop", amif_ready, 0);
    chk("no_restart", {m_axi_arvalid, m_axi_awvalid}, 0);
    amif_done = 0;
    if (!keep) begin amif_read = 0; amif_write = 0; end
  endtask

  task automatic start(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    tick();
    amif_read = rd; amif_write = wr; amif_addr = a; amif_store = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ra, rr, wa, ww, wb;
    bit rd;
    logic [31:0] a, d;
    amif_read = 0; amif_write = 0; amif_done = 0; amif_addr = '0; amif_store = '0;
    set_lat(0, 0, 0, 0, 0); cfg_rresp = 2'b00; cfg_bresp = 2'b00;
    forbid_wr = 0; saw_wr = 0; w_first = 0; ar_stalls = 0; exp_load = '0;
    s_rd_addr = '0; s_wr_addr = '0; s_wr_data = '0; s_wr_strb = '0;
    slave_clear();
    nrst = 0;
    repeat (2) @(negedge clk);
    chk_idle_outs("rst_outs");
    chk("rst_data", {amif_load, m_axi_araddr}, 0);
    chk("rst_wdata", {m_axi_wdata, m_axi_awaddr}, 0);
    chk("prot", {m_axi_arprot, m_axi_awprot}, 0);
`ifdef AXI_CTRL_ERR_EN
    chk("rst_err", amif_err, 0);
`endif
    nrst = 1;

    // zero-wait read, 4 cycles of done held low
    smem[32'h1000] = 32'hCAFE_F00D; emem[32'h1000] = 32'hCAFE_F00D;
    start(1, 0, 32'h1000, 0);
    txn_wait(3, 1, 32'h1000, 0, 4);
    chk("read_value", amif_load, 32'hCAFE_F00D);
    txn_close(0);

    // write with wready two cycles ahead of awready
    set_lat(0, 0, 2, 0, 0); w_first = 0;
    start(0, 1, 32'h10, 32'h1234_5678);
    txn_wait(5, 0, 32'h10, 32'h1234_5678, 1);
    chk("w_before_aw", w_first, 1);
    txn_close(0);
    set_lat(0, 0, 0, 0, 0);

    // read wins over write
    forbid_wr = 1; saw_wr = 0;
    start(1, 1, 32'h20, 32'hDEAD_BEEF);
    txn_wait(3, 1, 32'h20, 0, 0);
    txn_close(0);
    chk("read_wins", saw_wr, 0);
    forbid_wr = 0;

    // arready stalled five cycles
    set_lat(5, 0, 0, 0, 0); ar_stalls = 0;
    start(1, 0, 32'h10, 0);
    txn_wait(8, 1, 32'h10, 0, 0);
    chk("ar_stalls", ar_stalls, 5);
    txn_close(0);

    // done with read still high: no restart that cycle, restart the next
    set_lat(0, 0, 0, 0, 0);
    start(1, 0, 32'h1000, 0);
    txn_wait(3, 1, 32'h1000, 0, 0);
    txn_close(1);
    tick();
    chk("restart_arvalid", m_axi_arvalid, 1);
    txn_wait(-1, 1, 32'h1000, 0, 0);
    txn_close(0);

    // both requests dropped in RESP abandons the response
    start(0, 1, 32'h30, 32'h0BAD_F00D);
    txn_wait(3, 0, 32'h30, 32'h0BAD_F00D, 0);
    amif_write = 0;
    tick();
    chk_idle_outs("abandon_idle");

    // async reset while waiting in RD_DATA
    set_lat(0, 20, 0, 0, 0);
    start(1, 0, 32'h40, 0);
    n = 0;
    while (!m_axi_rready && n < 20) begin tick(); n++; end
    chk("reach_rd_data", m_axi_rready, 1);
    #2 nrst = 0;
    #1 chk_idle_outs("rst_async");
    amif_read = 0;
    slave_clear();
    exp_load = '0;
    @(negedge clk);
    nrst = 1;
    tick();
    chk_idle_outs("rst_release_idle");
    chk("rst_release_load", amif_load, 0);
    set_lat(0, 0, 0, 0, 0);
    start(1, 0, 32'h40, 0);
    txn_wait(3, 1, 32'h40, 0, 0);
    txn_close(0);

`ifdef AXI_CTRL_ERR_EN
    cfg_rresp = 2'b10;
    start(1, 0, 32'h1000, 0);
    txn_wait(3, 1, 32'h1000, 0, 0);
    chk("err_load_zero", {amif_err, amif_load}, {1'b1, 32'h0});
    txn_close(0);
    cfg_rresp = 2'b00; cfg_bresp = 2'b00;
    start(0, 1, 32'h44, 32'h5555_AAAA);
    txn_wait(3, 0, 32'h44, 32'h5555_AAAA, 0);
    chk("err_okay", amif_err, 0);
    txn_close(0);
`endif

    // randomized mix against the memory model
    for (int i = 0; i < 40; i++) begin
      rd = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 15)) << 2;
      d  = $urandom;
      ra = $urandom_range(0, 3); rr = $urandom_range(0, 3);
      wa = $urandom_range(0, 3); ww = $urandom_range(0, 3); wb = $urandom_range(0, 3);
      set_lat(ra, rr, wa, ww, wb);
      cfg_rresp = 2'($urandom_range(0, 3));
      cfg_bresp = 2'($urandom_range(0, 3));
      start(rd, !rd, a, d);
      txn_wait(rd ? 3 + ra + rr : 3 + ((wa > ww) ? wa : ww) + wb, rd, a, d, $urandom_range(0, 3));
      txn_close(0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
